// File: rtl/nibble_serial_addsub.sv
// Serial W-bit add/subtract engine: one nibble per clock through an external
// combinational 4-bit adder-subtractor slice, with valid/ready on both sides.
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_sub,
  output logic [3:0]           slice_a,
  output logic [3:0]           slice_b,
  output logic                 slice_cin,
  input  logic [3:0]           slice_sum,
  input  logic                 slice_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_result,
  output logic                 out_carry,
  output logic                 out_overflow
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    c_q, c_d;
  logic [NIBBLES-1:0][3:0] a_q, a_d;
  logic [NIBBLES-1:0][3:0] b_q, b_d;
  logic [NIBBLES-1:0][3:0] result_q, result_d;
  logic                    carry_q, carry_d;
  logic                    ovf_q, ovf_d;
  logic [3:0]              a_nib, b_nib;

  // Select the operand nibbles addressed by idx.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      a_nib = (idx_q == IW'(i)) ? a_q[i] : a_nib;
      b_nib = (idx_q == IW'(i)) ? b_q[i] : b_nib;
    end
  end

  // Next-state, datapath updates and slice drive.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    c_d       = c_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          c_d     = in_sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Pre-inverting b by the carry cancels the slice's own XOR on cin.
        slice_a   = a_nib;
        slice_b   = b_nib ^ {4{c_q}};
        slice_cin = c_q;
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) begin
            result_d[i] = slice_sum;
          end else begin
            result_d[i] = result_q[i];
          end
        end
        c_d   = slice_carry;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          carry_d = slice_carry;
          ovf_d   = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                    (slice_sum[3] != a_q[NIBBLES-1][3]);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      c_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_result   = result_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: a 16-bit and a 4-bit instance, each driving
// a behavioural slice, checked against an arithmetic reference model.
module tb_nibble_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 16-bit instance
  logic        in_valid4 = 1'b0, in_ready4, in_sub4 = 1'b0;
  logic [15:0] in_a4 = 16'd0, in_b4 = 16'd0;
  logic [3:0]  slice_a4, slice_b4, slice_sum4;
  logic        slice_cin4, slice_carry4;
  logic        out_valid4, out_ready4 = 1'b0, out_carry4, out_overflow4;
  logic [15:0] out_result4;

  // 4-bit instance
  logic        in_valid1 = 1'b0, in_ready1, in_sub1 = 1'b0;
  logic [3:0]  in_a1 = 4'd0, in_b1 = 4'd0;
  logic [3:0]  slice_a1, slice_b1, slice_sum1;
  logic        slice_cin1, slice_carry1;
  logic        out_valid1, out_ready1 = 1'b0, out_carry1, out_overflow1;
  logic [3:0]  out_result1;

  nibble_serial_addsub #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_sub(in_sub4),
    .slice_a(slice_a4), .slice_b(slice_b4), .slice_cin(slice_cin4),
    .slice_sum(slice_sum4), .slice_carry(slice_carry4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_result(out_result4), .out_carry(out_carry4), .out_overflow(out_overflow4)
  );

  nibble_serial_addsub #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1),
    .slice_a(slice_a1), .slice_b(slice_b1), .slice_cin(slice_cin1),
    .slice_sum(slice_sum1), .slice_carry(slice_carry1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_result(out_result1), .out_carry(out_carry1), .out_overflow(out_overflow1)
  );

  // Behavioural slices: sum = a + (b ^ {4{cin}}) + cin
  assign {slice_carry4, slice_sum4} = {1'b0, slice_a4} + {1'b0, slice_b4 ^ {4{slice_cin4}}} + {4'd0, slice_cin4};
  assign {slice_carry1, slice_sum1} = {1'b0, slice_a1} + {1'b0, slice_b1 ^ {4{slice_cin1}}} + {4'd0, slice_cin1};

  // Reference: returns {overflow, carry, result} for a w-bit operation.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a_in,
                                         input logic [31:0] b_in, input logic sub);
    logic [32:0] full;
    logic [31:0] mask, a, b, res;
    logic carry, ovf, sa, sb, sr;
    mask = (32'd1 << w) - 32'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (sub) begin
      full  = {1'b0, a} - {1'b0, b};
      carry = (a >= b);
    end else begin
      full  = {1'b0, a} + {1'b0, b};
      carry = full[w];
    end
    res = full[31:0] & mask;
    sa = a[w-1];
    sb = b[w-1];
    sr = res[w-1];
    ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ovf, carry, res};
  endfunction

  // Issue one operation to dut4, leaving out_ready low; returns with DONE observed.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic sub,
                     output logic [15:0] res, output logic car, output logic ovf,
                     output int lat, output logic [3:0] cins);
    int guard;
    @(negedge clk);
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_sub4 = sub;
    guard = 0;
    while (!in_ready4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_sub4 = 1'($urandom);
    lat = 0;
    cins = 4'd0;
    while (!out_valid4 && lat < 20) begin
      if (lat < 4) cins[lat] = slice_cin4;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = out_result4; car = out_carry4; ovf = out_overflow4;
  endtask

  task automatic release4();
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1 0", in_ready4, out_valid4);
    end
    n_checks++;
    if ({out_result4, out_carry4, out_overflow4} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: result=%h carry=%b ovf=%b, expected 0", out_result4, out_carry4, out_overflow4);
    end
    n_checks++;
    if ({slice_a4, slice_b4, slice_cin4} !== 9'd0) begin
      n_fail++; $display("FAIL reset_slice: a=%h b=%h cin=%b, expected 0", slice_a4, slice_b4, slice_cin4);
    end
  endtask

  task automatic test_fixed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [15:0] exp_res,
                            input logic exp_car, input logic exp_ovf);
    logic [15:0] res; logic car, ovf; int lat; logic [3:0] cins;
    op4(a, b, sub, res, car, ovf, lat, cins);
    n_checks++;
    if ({res, car, ovf} !== {exp_res, exp_car, exp_ovf}) begin
      n_fail++; $display("FAIL %s: result=%h carry=%b ovf=%b, expected %h %b %b", name, res, car, ovf, exp_res, exp_car, exp_ovf);
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL %s_latency: %0d edges, expected 4", name, lat);
    end
    if (sub && a == 16'h0005) begin
      n_checks++;
      if (cins !== 4'b0001) begin
        n_fail++; $display("FAIL %s_cin_trace: %b (idx3..0), expected 0001", name, cins);
      end
    end
    release4();
  endtask

  task automatic test_backpressure();
    logic [15:0] res; logic car, ovf; int lat; logic [3:0] cins;
    bit stable_ok, ready_low;
    int guard;
    op4(16'h1234, 16'h0F0F, 1'b0, res, car, ovf, lat, cins);
    in_valid4 = 1'b1; in_a4 = 16'h4321; in_b4 = 16'h1111; in_sub4 = 1'b1;
    stable_ok = 1'b1; ready_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid4 !== 1'b1 || {out_result4, out_carry4, out_overflow4} !== {res, car, ovf}) stable_ok = 1'b0;
      if (in_ready4 !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!stable_ok) begin
      n_fail++; $display("FAIL bp_hold: result=%h valid=%b, expected held %h valid 1", out_result4, out_valid4, res);
    end
    n_checks++;
    if (!ready_low) begin
      n_fail++; $display("FAIL bp_in_ready: in_ready went high during DONE, expected 0");
    end
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    n_checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1 0", in_ready4, out_valid4);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    guard = 0;
    while (!out_valid4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if ({out_valid4, out_result4, out_carry4, out_overflow4} !== {1'b1, 16'h3210, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bp_pending_op: valid=%b result=%h carry=%b ovf=%b, expected 1 3210 1 0",
                         out_valid4, out_result4, out_carry4, out_overflow4);
    end
    release4();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] res; logic car, ovf; int lat; logic [3:0] cins;
    bit no_valid;
    @(negedge clk);
    in_valid4 = 1'b1; in_a4 = 16'h1111; in_b4 = 16'h2222; in_sub4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (slice_a4 !== 4'h1 || slice_b4 !== 4'h2) begin
      n_fail++; $display("FAIL rst_run_precheck: slice_a=%h slice_b=%h, expected 1 2", slice_a4, slice_b4);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready4, out_valid4, out_result4, out_carry4, out_overflow4, slice_a4, slice_b4, slice_cin4} !== {1'b1, 28'd0}) begin
      n_fail++; $display("FAIL rst_mid_run: in_ready=%b valid=%b result=%h carry=%b ovf=%b slice=%h/%h/%b, expected 1 and zeros",
                         in_ready4, out_valid4, out_result4, out_carry4, out_overflow4, slice_a4, slice_b4, slice_cin4);
    end
    no_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid4 !== 1'b0) no_valid = 1'b0;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid4 !== 1'b0) no_valid = 1'b0;
    end
    n_checks++;
    if (!no_valid) begin
      n_fail++; $display("FAIL rst_no_result: out_valid rose after reset, expected 0");
    end
    op4(16'h0001, 16'h0001, 1'b0, res, car, ovf, lat, cins);
    n_checks++;
    if ({res, car, ovf} !== {16'h0002, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_recover: result=%h carry=%b ovf=%b, expected 0002 0 0", res, car, ovf);
    end
    release4();
  endtask

  task automatic test_back_to_back4();
    logic [33:0] q[$];
    logic [33:0] e;
    int last_acc, gap_bad, done_cnt;
    last_acc = -1; gap_bad = 0; done_cnt = 0;
    out_ready4 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      in_valid4 = 1'b1;
      in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_sub4 = 1'($urandom);
      if (in_ready4) begin
        q.push_back(ref_op(16, {16'd0, in_a4}, {16'd0, in_b4}, in_sub4));
        if (last_acc >= 0 && cyc - last_acc != 6) gap_bad++;
        last_acc = cyc;
      end
      if (out_valid4) begin
        done_cnt++;
        e = (q.size() > 0) ? q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({out_overflow4, out_carry4, out_result4} !== {e[33:32], e[15:0]}) begin
          n_fail++; $display("FAIL b2b4_result: result=%h carry=%b ovf=%b, expected %h %b %b",
                             out_result4, out_carry4, out_overflow4, e[15:0], e[32], e[33]);
        end
      end
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    n_checks++;
    if (gap_bad != 0 || done_cnt < 8) begin
      n_fail++; $display("FAIL b2b4_throughput: %0d bad gaps, %0d results, expected 0 bad gaps and >=8 results", gap_bad, done_cnt);
    end
    repeat (8) @(negedge clk);
    release4();
  endtask

  task automatic test_nib1_basic();
    int lat;
    logic [33:0] e;
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = 4'h9; in_b1 = 4'h3; in_sub1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL nib1_latency: %0d edges, expected 1", lat);
    end
    // -7 - 3 does not fit in signed 4 bits, so overflow is expected set.
    e = ref_op(4, 32'h9, 32'h3, 1'b1);
    n_checks++;
    if ({out_result1, out_carry1, out_overflow1} !== {4'h6, 1'b1, e[33]}) begin
      n_fail++; $display("FAIL nib1_sub: result=%h carry=%b ovf=%b, expected 6 1 %b", out_result1, out_carry1, out_overflow1, e[33]);
    end
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
  endtask

  task automatic test_nib1_random();
    logic [33:0] q[$];
    logic [33:0] e;
    int both_hi;
    both_hi = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid1 = ($urandom_range(0, 3) != 0);
      in_a1 = 4'($urandom); in_b1 = 4'($urandom); in_sub1 = 1'($urandom);
      out_ready1 = ($urandom_range(0, 2) != 0);
      if (in_ready1 && out_valid1) both_hi++;
      if (in_valid1 && in_ready1)
        q.push_back(ref_op(4, {28'd0, in_a1}, {28'd0, in_b1}, in_sub1));
      if (out_valid1 && out_ready1) begin
        e = (q.size() > 0) ? q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({out_overflow1, out_carry1, out_result1} !== {e[33:32], e[3:0]}) begin
          n_fail++; $display("FAIL nib1_rand: result=%h carry=%b ovf=%b, expected %h %b %b",
                             out_result1, out_carry1, out_overflow1, e[3:0], e[32], e[33]);
        end
      end
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid1) begin
        e = (q.size() > 0) ? q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({out_overflow1, out_carry1, out_result1} !== {e[33:32], e[3:0]}) begin
          n_fail++; $display("FAIL nib1_drain: result=%h, expected %h", out_result1, e[3:0]);
        end
      end
    end
    out_ready1 = 1'b0;
    n_checks++;
    if (q.size() != 0 || both_hi != 0) begin
      n_fail++; $display("FAIL nib1_scoreboard: %0d outstanding, %0d cycles ready&valid, expected 0 0", q.size(), both_hi);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_fixed("add",        16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0);
    test_fixed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_fixed("wrap",       16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_fixed("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_fixed("ovf_sub",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back4();
    test_nib1_basic();
    test_nib1_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
